seg_sequence_ctrl: RTL and testbench

Sequencing controller for the 4-bit symbol value feeding the team's seven-segment decoder. It replaces the free-running one-second counter with a programmable sequencer:
- run/pause FSM
- selectable tick period
- up/down direction with live wrap bounds
- single-step and clear controls

Output is the 4-bit value plus one-cycle update/wrap strobes for the decoder and any status logic.

---
 rtl/seg_sequence_ctrl_if.sv | 33 +++
 rtl/seg_sequence_ctrl.sv | 151 +++++++++++++++
 tb/tb_seg_sequence_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_sequence_ctrl_if.sv
// ============================================================================
//  Module   : seg_sequence_ctrl_if
//  Brief    : Control/status bundle between a sequencer client and
//             seg_sequence_ctrl (run/step/bounds in, symbol and strobes out).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_sequence_ctrl_if;
    logic       enable;
    logic       clear;
    logic       dir;
    logic       step;
    logic [1:0] period_sel;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] value;
    logic       update;
    logic       wrap;
    logic [1:0] state;

    modport master (
        output enable, clear, dir, step, period_sel, lo, hi,
        input  value, update, wrap, state
    );

    modport slave (
        input  enable, clear, dir, step, period_sel, lo, hi,
        output value, update, wrap, state
    );
endinterface

`default_nettype wire

// File: rtl/seg_sequence_ctrl.sv
// ============================================================================
//  Module   : seg_sequence_ctrl
//  Brief    : Programmable run/pause/step sequencer producing the 4-bit symbol
//             index for the seven-segment decoder, with update/wrap strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_sequence_ctrl #(
    parameter int TICK_DIV = 10_000_000,
    parameter int CNT_W    = 24
) (
    input  wire logic          clk,
    input  wire logic          rst,
    seg_sequence_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // One extra bit so TICK_DIV == 2**CNT_W is representable.
    localparam logic [CNT_W:0] c_tick_div = (CNT_W+1)'(TICK_DIV);
    localparam logic [CNT_W:0] c_one      = (CNT_W+1)'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_value;
    logic [3:0]       w_value_nxt;
    logic             r_update;
    logic             w_update_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_nxt;
    logic             r_step_q;

    logic [3:0]       w_eff_lo;
    logic [3:0]       w_eff_hi;
    logic [CNT_W:0]   w_shifted;
    logic [CNT_W:0]   w_period;
    logic [CNT_W:0]   w_presc_inc;
    logic             w_tick;
    logic             w_step_edge;
    logic [3:0]       w_adv_value;
    logic             w_adv_wrap;

    assign w_eff_lo    = (bus.lo < bus.hi) ? bus.lo : bus.hi;
    assign w_eff_hi    = (bus.lo < bus.hi) ? bus.hi : bus.lo;
    assign w_shifted   = c_tick_div >> bus.period_sel;
    assign w_period    = (w_shifted == '0) ? c_one : w_shifted;
    assign w_presc_inc = {1'b0, r_presc} + c_one;
    // presc+1 >= period is presc >= period-1 without an underflow case.
    assign w_tick      = (w_presc_inc >= w_period);
    assign w_step_edge = bus.step & ~r_step_q;

    // Out-of-range values wrap before the +/-1, so no 4-bit overflow occurs.
    always_comb begin
        w_adv_value = r_value;
        w_adv_wrap  = 1'b0;
        if (!bus.dir) begin
            if (r_value >= w_eff_hi) begin
                w_adv_value = w_eff_lo;
                w_adv_wrap  = 1'b1;
            end else begin
                w_adv_value = r_value + 4'd1;
            end
        end else begin
            if (r_value <= w_eff_lo) begin
                w_adv_value = w_eff_hi;
                w_adv_wrap  = 1'b1;
            end else begin
                w_adv_value = r_value - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_value_nxt  = r_value;
        w_update_nxt = 1'b0;
        w_wrap_nxt   = 1'b0;
        w_presc_nxt  = '0;
        if (bus.clear) begin
            w_state_nxt = IDLE;
            w_value_nxt = w_eff_lo;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        w_state_nxt  = RUN;
                        w_value_nxt  = w_eff_lo;
                        w_update_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        w_state_nxt = PAUSE;
                    end else if (w_tick) begin
                        w_value_nxt  = w_adv_value;
                        w_wrap_nxt   = w_adv_wrap;
                        w_update_nxt = 1'b1;
                    end else begin
                        w_presc_nxt = w_presc_inc[CNT_W-1:0];
                    end
                end
                PAUSE: begin
                    // Resuming wins over a simultaneous step edge.
                    if (bus.enable) begin
                        w_state_nxt = RUN;
                    end else if (w_step_edge) begin
                        w_value_nxt  = w_adv_value;
                        w_wrap_nxt   = w_adv_wrap;
                        w_update_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_value  <= 4'd0;
            r_update <= 1'b0;
            r_wrap   <= 1'b0;
            r_presc  <= '0;
            r_step_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_value  <= w_value_nxt;
            r_update <= w_update_nxt;
            r_wrap   <= w_wrap_nxt;
            r_presc  <= w_presc_nxt;
            r_step_q <= bus.step;
        end
    end

    assign bus.value  = r_value;
    assign bus.update = r_update;
    assign bus.wrap   = r_wrap;
    assign bus.state  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_seg_sequence_ctrl.sv
// ============================================================================
//  Module   : tb_seg_sequence_ctrl
//  Brief    : Self-checking bench for seg_sequence_ctrl (TICK_DIV=4) using a
//             cycle-level behavioural model plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_sequence_ctrl;

    localparam int c_tdiv = 4;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    seg_sequence_ctrl_if bus ();

    seg_sequence_ctrl #(
        .TICK_DIV (c_tdiv),
        .CNT_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: state codes 0=IDLE 1=RUN 2=PAUSE, m_since counts
    // RUN cycles since the run was entered or the last advance.
    logic [3:0] m_value;
    logic       m_upd;
    logic       m_wrap;
    logic [1:0] m_state;
    int         m_since;
    logic       m_stepq;

    function automatic void advance(input int v, input bit d, input int elo,
                                    input int ehi, output int nv, output bit nw);
        nw = 1'b0;
        if (!d) begin
            if (v >= ehi) begin nv = elo; nw = 1'b1; end
            else nv = v + 1;
        end else begin
            if (v <= elo) begin nv = ehi; nw = 1'b1; end
            else nv = v - 1;
        end
    endfunction

    always @(posedge clk or posedge rst) begin : model_step
        int elo, ehi, per, nv, ns, nsince;
        bit nw, nu, se;
        if (rst) begin
            m_value <= 4'd0; m_upd <= 1'b0; m_wrap <= 1'b0;
            m_state <= 2'd0; m_since <= 0; m_stepq <= 1'b0;
        end else begin
            elo = (bus.lo < bus.hi) ? int'(bus.lo) : int'(bus.hi);
            ehi = (bus.lo < bus.hi) ? int'(bus.hi) : int'(bus.lo);
            per = c_tdiv >> bus.period_sel;
            if (per < 1) per = 1;
            se = bus.step && !m_stepq;
            nv = int'(m_value); nw = 1'b0; nu = 1'b0; ns = int'(m_state); nsince = 0;
            if (bus.clear) begin
                ns = 0; nv = elo;
            end else if (m_state == 2'd0) begin
                if (bus.enable) begin ns = 1; nv = elo; nu = 1'b1; end
            end else if (m_state == 2'd1) begin
                if (!bus.enable) ns = 2;
                else if (m_since + 1 >= per) begin
                    advance(int'(m_value), bus.dir, elo, ehi, nv, nw); nu = 1'b1;
                end else nsince = m_since + 1;
            end else begin
                if (bus.enable) ns = 1;
                else if (se) begin
                    advance(int'(m_value), bus.dir, elo, ehi, nv, nw); nu = 1'b1;
                end
            end
            m_value <= 4'(nv); m_upd <= nu; m_wrap <= nw;
            m_state <= 2'(ns); m_since <= nsince; m_stepq <= bus.step;
        end
    end

    always @(negedge clk) begin
        chk("cycle{value,update,wrap,state}",
            {24'd0, bus.value, bus.update, bus.wrap, bus.state},
            int'({m_value, m_upd, m_wrap, m_state}));
    end

    task automatic wait_upd(input string nm, output int v, output int w, output int cyc);
        cyc = 0; v = -1; w = -1;
        repeat (40) begin
            @(negedge clk);
            cyc++;
            if (bus.update === 1'b1) begin
                v = int'(bus.value); w = int'(bus.wrap);
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL %s: got no update in 40 cycles expected an update", nm);
    endtask

    initial begin
        int v, w, c, cnt, found;
        int exp1 [5]  = '{2, 3, 4, 5, 2};
        int expw1[5]  = '{0, 0, 0, 0, 1};
        int exp2 [9]  = '{7, 6, 5, 4, 3, 7, 6, 5, 4};
        int expw2[9]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};

        rst = 1'b1;
        bus.enable = 1'b0; bus.clear = 1'b0; bus.dir = 1'b0; bus.step = 1'b0;
        bus.period_sel = 2'd0; bus.lo = 4'd0; bus.hi = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {24'd0, bus.value, bus.update, bus.wrap, bus.state}, 0);

        // Up-count 2..5 with 4 cycles per symbol.
        rst = 1'b0;
        bus.lo = 4'd2; bus.hi = 4'd5; bus.enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_upd("up_seq", v, w, c);
            chk($sformatf("up_val%0d", i), v, exp1[i]);
            chk($sformatf("up_wrap%0d", i), w, expw1[i]);
            if (i == 0) chk("idle_to_run_latency", c, 1);
            else chk($sformatf("up_gap%0d", i), c, 4);
        end

        // Down-count 7..3 with live bound change.
        bus.dir = 1'b1; bus.lo = 4'd3; bus.hi = 4'd7;
        for (int i = 0; i < 9; i++) begin
            wait_upd("down_seq", v, w, c);
            chk($sformatf("down_val%0d", i), v, exp2[i]);
            chk($sformatf("down_wrap%0d", i), w, expw2[i]);
        end

        // Drop enable exactly on the tick cycle.
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("pause_state", bus.state, 2);
        chk("pause_value", bus.value, 4);
        chk("pause_no_update", bus.update, 0);

        bus.dir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.step = 1'b1;
            @(negedge clk);
            chk($sformatf("step_upd%0d", k), bus.update, 1);
            chk($sformatf("step_val%0d", k), bus.value, 5 + k);
            bus.step = 1'b0;
            @(negedge clk);
            chk($sformatf("step_quiet%0d", k), bus.update, 0);
        end
        bus.step = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.update === 1'b1) cnt++;
        end
        bus.step = 1'b0;
        chk("step_hold_count", cnt, 1);
        chk("step_hold_value", bus.value, 3);
        @(negedge clk);

        // Reach value 12, then swapped bounds wrap it to 1.
        bus.lo = 4'd12; bus.hi = 4'd12; bus.dir = 1'b1; bus.step = 1'b1;
        @(negedge clk);
        chk("to12_value", bus.value, 12);
        bus.step = 1'b0;
        @(negedge clk);
        bus.lo = 4'd9; bus.hi = 4'd1; bus.dir = 1'b0; bus.step = 1'b1;
        @(negedge clk);
        chk("swap_value", bus.value, 1);
        chk("swap_wrap", bus.wrap, 1);
        bus.step = 1'b0;

        // period_sel=3 gives period 1.
        bus.lo = 4'd0; bus.hi = 4'd15; bus.period_sel = 2'd3; bus.enable = 1'b1;
        @(negedge clk);
        chk("resume_state", bus.state, 1);
        chk("resume_no_update", bus.update, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("fast_upd%0d", i), bus.update, 1);
            chk($sformatf("fast_val%0d", i), bus.value, 2 + i);
        end
        bus.period_sel = 2'd0;
        repeat (2) begin
            @(negedge clk);
            chk("slow_quiet", bus.update, 0);
        end
        bus.period_sel = 2'd2;
        @(negedge clk);
        chk("shrink_tick_upd", bus.update, 1);
        chk("shrink_tick_val", bus.value, 7);

        // Clear in RUN at value 6.
        bus.period_sel = 2'd0; bus.lo = 4'd2; bus.hi = 4'd9;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            wait_upd("seek6", v, w, c);
            if (v == 6) found = 1;
        end
        chk("seek6_found", found, 1);
        bus.clear = 1'b1;
        @(negedge clk);
        chk("clear_state", bus.state, 0);
        chk("clear_value", bus.value, 2);
        chk("clear_no_update", bus.update, 0);
        bus.clear = 1'b0;
        @(negedge clk);
        chk("restart_value", bus.value, 2);
        chk("restart_update", bus.update, 1);

        // Async reset between clock edges.
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", {24'd0, bus.value, bus.update, bus.wrap, bus.state}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.enable = ~bus.enable;
            bus.clear = ($urandom_range(0, 99) == 0);
            bus.step  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 63) == 0) bus.period_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) bus.lo = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) bus.hi = 4'($urandom_range(0, 15));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
